sar_logic: RTL
==============

// Module: sar_logic
// PURPOSE
//  Successive-approximation controller for the SAR-ADC model; sits directly downstream of the sample/hold.
//  Drives the sample/hold clock, steps a binary-search code into the capacitive DAC and consumes the comparator decision.
//  Emits one NBITS-wide result per conversion, qualified by a single-cycle valid strobe.
// PARAMETERS
//  NBITS          8   resolution in bits; legal range >= 2
//  SAMPLE_CYCLES  2   cycles the sample phase holds 'sample' high; legal range >= 1
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  rst       in   1      asynchronous, active-low reset (0 = reset)
//  start     in   1      conversion request; sampled only in IDLE
//  comp      in   1      comparator decision; 1 = held input >= current DAC code
//  sample    out  1      sample/hold clock; 1 = track, 0 = hold
//  dac_code  out  NBITS  trial code driven to the DAC
//  dout      out  NBITS  last completed conversion result
//  valid     out  1      1-cycle strobe; dout updated at the same edge
//  busy      out  1      1 from start acceptance until the valid edge
// BEHAVIOUR
//  - Reset: rst=0 forces, immediately and asynchronously, state=IDLE and sample=dac_code=dout=valid=busy=0, all counters=0.
//  - All outputs are registered; no combinational path from any input to any output.
//  - FSM states: IDLE -> SAMPLE -> CONVERT -> IDLE.
//  - IDLE: if start=1 at edge E0 -> SAMPLE; same edge sets sample=1, busy=1.
//  - SAMPLE: stays for SAMPLE_CYCLES edges.
//    - At edge E0+SAMPLE_CYCLES -> CONVERT; same edge sets sample=0, dac_code=1<<(NBITS-1), bit_idx=NBITS-1.
//  - CONVERT: each edge evaluates comp against the present dac_code.
//    - dac_code[bit_idx] <= comp.
//    - If bit_idx>0: dac_code[bit_idx-1] <= 1 and bit_idx decrements.
//  - Bit 0 decision edge (E0+SAMPLE_CYCLES+NBITS):
//    - dout <= final code (MSB..bit1 as decided, bit0 = comp); valid=1 for exactly one cycle; busy=0; state -> IDLE.
//  - Latency: start edge to valid edge = SAMPLE_CYCLES+NBITS cycles (10 at defaults).
//  - dac_code holds the final code in IDLE until the next CONVERT entry.
//  - dout holds until the next valid.
//  - start is ignored while busy=1, including at the valid edge itself.
//    - start held high continuously yields a new conversion every SAMPLE_CYCLES+NBITS+1 cycles.
//  - comp is ignored outside CONVERT.
//  - bit_idx is $clog2(NBITS) wide and never wraps below 0.
//  - Reset mid-conversion: abandons the conversion; no valid; dout=0.
//    - A fresh start is required after rst returns to 1.
// CONFIGURATION
//  SAR_CONTINUOUS_EN
//  - Defined: free-running mode; start is ignored and busy is tied high after reset release.
//    - First edge with rst=1 enters SAMPLE.
//    - The valid edge goes directly to SAMPLE (sample=1) instead of IDLE.
//    - Period = SAMPLE_CYCLES+NBITS cycles.
//  - Undefined: start-triggered behaviour as described above.
// TESTING
//  1. Comparator model comp=(0xA5>=dac_code), pulse start -> after 10 cycles dout=0xA5, valid high exactly 1 cycle.
//     Trial code sequence: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
//  2. comp tied 1 -> dout=0xFF; comp tied 0 -> dout=0x00; sample high exactly 2 cycles in each conversion.
//  3. start pulsed at cycles 3 and 9 after an accepted start -> both ignored, exactly one valid.
//     start held high for 40 cycles -> valid every 11 cycles.
//  4. rst=0 asserted 5 cycles into a conversion -> all outputs 0 immediately with no valid.
//     After release with no start -> stays IDLE; new start -> normal result.
//  5. SAR_CONTINUOUS_EN defined, comp model of 0x3C -> dout=0x3C with valid every 10 cycles; start toggling has no effect.
//  6. Back-to-back conversions with inputs 0x00 then 0xFF (non-continuous mode) -> dout 0x00 then 0xFF.
//     dout stable between the two valid strobes.

Source files
------------

// File: rtl/sar_logic_if.sv
// sar_logic_if: bus between the SAR controller and its analog neighbours.
//   start    : conversion request (host -> controller)
//   comp     : comparator decision, 1 = held input >= dac_code
//   sample   : sample/hold clock, 1 = track, 0 = hold
//   dac_code : trial code driven to the capacitive DAC
//   dout     : last completed conversion result
//   valid    : one-cycle strobe, dout updated at the same edge
//   busy     : high from start acceptance until the valid edge
// The master modport is the controller; slave is the surrounding model/host.
interface sar_logic_if #(
    parameter int NBITS = 8
);
    logic             start;
    logic             comp;
    logic             sample;
    logic [NBITS-1:0] dac_code;
    logic [NBITS-1:0] dout;
    logic             valid;
    logic             busy;

    modport master (
        input  start, comp,
        output sample, dac_code, dout, valid, busy
    );

    modport slave (
        output start, comp,
        input  sample, dac_code, dout, valid, busy
    );
endinterface

// File: rtl/sar_logic.sv
// sar_logic: successive-approximation controller for the SAR-ADC model.
// Drives the sample/hold clock, walks a binary-search code through the DAC
// (MSB first, one bit per cycle) and emits one NBITS result per conversion.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sar_logic_if.master (start, comp in; sample, dac_code, dout,
//          valid, busy out -- all outputs registered)
// Parameters: NBITS (>= 2) resolution, SAMPLE_CYCLES (>= 1) track time.
// Build option: define SAR_CONTINUOUS_EN for free-running conversions
// (start ignored, valid edge re-enters SAMPLE directly).
module sar_logic #(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    sar_logic_if.master  bus
);
    localparam int BW = $clog2(NBITS);
    localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    localparam logic [SW-1:0]    SLAST = SW'(SAMPLE_CYCLES - 1);
    localparam logic [BW-1:0]    TOP   = BW'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB   = {1'b1, {(NBITS-1){1'b0}}};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SAMPLE  = 2'd1;
    localparam logic [1:0] CONVERT = 2'd2;

`ifdef SAR_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic [1:0]       state;
    logic [SW-1:0]    scnt;
    logic [BW-1:0]    bit_idx;
    logic             sample_q;
    logic             valid_q;
    logic             busy_q;
    logic [NBITS-1:0] dac_q;
    logic [NBITS-1:0] dout_q;
    logic [NBITS-1:0] code_nxt;
    logic             go;

    // In free-running mode every IDLE edge launches a conversion.
    assign go = CONT ? 1'b1 : bus.start;

    // Resolve the current bit with the comparator and arm the next trial bit.
    // At bit 0 this is the final code, so it also feeds dout.
    always_comb begin
        code_nxt = dac_q;
        code_nxt[bit_idx] = bus.comp;
        if (bit_idx != '0)
            code_nxt[bit_idx - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            scnt     <= '0;
            bit_idx  <= '0;
            sample_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            dac_q    <= '0;
            dout_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= SAMPLE;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                        scnt     <= '0;
                    end
                end
                SAMPLE: begin
                    if (scnt == SLAST) begin
                        state    <= CONVERT;
                        sample_q <= 1'b0;
                        dac_q    <= MSB;
                        bit_idx  <= TOP;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                CONVERT: begin
                    dac_q <= code_nxt;
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                    end else begin
                        dout_q  <= code_nxt;
                        valid_q <= 1'b1;
                        if (CONT) begin
                            // Skip IDLE so the period is SAMPLE_CYCLES+NBITS.
                            state    <= SAMPLE;
                            sample_q <= 1'b1;
                            scnt     <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sample   = sample_q;
    assign bus.dac_code = dac_q;
    assign bus.dout     = dout_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
endmodule
